// File: rtl/data_switch_hold.sv
// Three-segment data bus (pin / ALU / register file) joined by two bidirectional
// switches, with per-segment hold registers and a sticky, counted conflict monitor.
module data_switch_hold #(
    parameter logic [7:0] HOLD_RESET_VALUE = 8'hFF,
    parameter int         CNT_W            = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_sw_1u,
    input  logic             bus_sw_1d,
    input  logic             bus_sw_2u,
    input  logic             bus_sw_2d,
    input  logic             bus_sw_mask543_en,
    input  logic             db0_we,
    input  logic [7:0]       db0_wd,
    input  logic             db1_we,
    input  logic [7:0]       db1_wd,
    input  logic             db2_we,
    input  logic [7:0]       db2_wd,
    input  logic             conflict_clr,
    output logic [7:0]       db0,
    output logic [7:0]       db1,
    output logic [7:0]       db2,
    output logic             bus_conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [7:0]       r_hold0;
    logic [7:0]       r_hold1;
    logic [7:0]       r_hold2;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;

    // A switch conducts only when exactly one direction is requested.
    logic w_sw1Up;
    logic w_sw1Dn;
    logic w_sw2Up;
    logic w_sw2Dn;
    assign w_sw1Up = bus_sw_1u & ~bus_sw_1d;
    assign w_sw1Dn = bus_sw_1d & ~bus_sw_1u;
    assign w_sw2Up = bus_sw_2u & ~bus_sw_2d;
    assign w_sw2Dn = bus_sw_2d & ~bus_sw_2u;

    logic [7:0] w_base0;
    logic [7:0] w_base2;
    assign w_base0 = db0_we ? db0_wd : r_hold0;
    assign w_base2 = db2_we ? db2_wd : r_hold2;

    // Segment 1 is resolved first: an active switch into it implies the far
    // segment is not itself fed from segment 1, so using its base value breaks
    // the combinational loop. If both switches feed it, SW1 wins.
    assign db1 = db1_we  ? db1_wd  :
                 w_sw1Up ? w_base0 :
                 w_sw2Dn ? w_base2 :
                           r_hold1;

    assign db0 = db0_we  ? db0_wd :
                 w_sw1Dn ? (bus_sw_mask543_en ? (db1 & 8'hC7) : db1) :
                           r_hold0;

    assign db2 = db2_we  ? db2_wd :
                 w_sw2Up ? db1    :
                           r_hold2;

    logic w_conflict;
    assign w_conflict = (bus_sw_1u & bus_sw_1d) |
                        (bus_sw_2u & bus_sw_2d) |
                        (db0_we & w_sw1Dn) |
                        (db1_we & (w_sw1Up | w_sw2Dn)) |
                        (db2_we & w_sw2Up);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold0    <= HOLD_RESET_VALUE;
            r_hold1    <= HOLD_RESET_VALUE;
            r_hold2    <= HOLD_RESET_VALUE;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_hold0 <= db0;
            r_hold1 <= db1;
            r_hold2 <= db2;
            if (conflict_clr) begin
                r_conflict <= 1'b0;
                r_cnt      <= '0;
            end else if (w_conflict) begin
                r_conflict <= 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus_conflict = r_conflict;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_data_switch_hold.sv
// Randomised bench for data_switch_hold: a segment-graph reference model predicts
// each cycle's outputs into a queue which a negedge monitor pops and compares.
module tb_data_switch_hold;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw1u, sw1d, sw2u, sw2d, mask543;
    logic       we0, we1, we2;
    logic [7:0] wd0, wd1, wd2;
    logic       clr;
    logic [7:0] db0, db1, db2;
    logic       busConflict;
    logic [3:0] conflictCnt;

    always #5 clk = ~clk;

    data_switch_hold #(.HOLD_RESET_VALUE(8'hFF), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .bus_sw_1u(sw1u), .bus_sw_1d(sw1d), .bus_sw_2u(sw2u), .bus_sw_2d(sw2d),
        .bus_sw_mask543_en(mask543),
        .db0_we(we0), .db0_wd(wd0), .db1_we(we1), .db1_wd(wd1),
        .db2_we(we2), .db2_wd(wd2),
        .conflict_clr(clr),
        .db0(db0), .db1(db1), .db2(db2),
        .bus_conflict(busConflict), .conflict_cnt(conflictCnt)
    );

    typedef struct packed {
        logic       rst, clr, mask;
        logic       s1u, s1d, s2u, s2d;
        logic [2:0] we;
        logic [7:0] wd0, wd1, wd2;
    } stim_t;

    typedef struct packed {
        logic [7:0] d0, d1, d2;
        logic       flag;
        logic [3:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    bit   driverDone = 0;
    bit   monitorDone = 0;

    // Reference model state: what each segment would read if left alone.
    logic [2:0][7:0] mHold;
    logic            mFlag;
    int              mCnt;

    // Segment values found by repeatedly pulling from active incoming switches;
    // a locally driven segment never changes, an isolated one reads its hold.
    task automatic modelEval(input stim_t s, output logic [2:0][7:0] v, output bit conf);
        int         eSrc[4]  = '{0, 2, 1, 1};
        int         eDst[4]  = '{1, 1, 0, 2};
        bit         eAct[4];
        logic [2:0][7:0] nv;
        eAct[0] = s.s1u && !s.s1d;
        eAct[1] = s.s2d && !s.s2u;
        eAct[2] = s.s1d && !s.s1u;
        eAct[3] = s.s2u && !s.s2d;
        v[0] = s.we[0] ? s.wd0 : mHold[0];
        v[1] = s.we[1] ? s.wd1 : mHold[1];
        v[2] = s.we[2] ? s.wd2 : mHold[2];
        for (int it = 0; it < 3; it++) begin
            nv = v;
            for (int n = 0; n < 3; n++) begin
                if (!s.we[n]) begin
                    bit got = 0;
                    nv[n] = mHold[n];
                    for (int e = 0; e < 4; e++) begin
                        if (!got && eAct[e] && eDst[e] == n) begin
                            got = 1;
                            nv[n] = v[eSrc[e]];
                            if (e == 2 && s.mask) nv[n] = nv[n] & 8'hC7;
                        end
                    end
                end
            end
            v = nv;
        end
        conf = (s.s1u && s.s1d) || (s.s2u && s.s2d);
        for (int e = 0; e < 4; e++) begin
            if (eAct[e] && s.we[eDst[e]]) conf = 1;
        end
    endtask

    // Called just after a rising edge: drives one cycle, predicts, advances model.
    task automatic applyStimulus(input stim_t s);
        logic [2:0][7:0] v;
        bit              conf;
        exp_t            e;
        reset = s.rst; clr = s.clr; mask543 = s.mask;
        sw1u = s.s1u; sw1d = s.s1d; sw2u = s.s2u; sw2d = s.s2d;
        we0 = s.we[0]; we1 = s.we[1]; we2 = s.we[2];
        wd0 = s.wd0; wd1 = s.wd1; wd2 = s.wd2;
        modelEval(s, v, conf);
        e.d0 = v[0]; e.d1 = v[1]; e.d2 = v[2];
        e.flag = mFlag; e.cnt = mCnt[3:0];
        expQ.push_back(e);
        @(posedge clk);
        if (s.rst) begin
            mHold = {3{8'hFF}};
            mFlag = 0;
            mCnt  = 0;
        end else begin
            mHold = v;
            if (s.clr) begin
                mFlag = 0;
                mCnt  = 0;
            end else if (conf) begin
                mFlag = 1;
                mCnt  = (mCnt < 15) ? mCnt + 1 : 15;
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    // Monitor: compares every predicted cycle while the DUT outputs are stable.
    initial begin : monitor
        exp_t e;
        int   spins = 0;
        while (!(driverDone && expQ.size() == 0) && spins < 5000) begin
            @(negedge clk);
            spins++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("db0", int'(db0), int'(e.d0));
                checkOutput("db1", int'(db1), int'(e.d1));
                checkOutput("db2", int'(db2), int'(e.d2));
                checkOutput("bus_conflict", int'(busConflict), int'(e.flag));
                checkOutput("conflict_cnt", int'(conflictCnt), int'(e.cnt));
            end
        end
        if (spins >= 5000) begin
            checks++;
            $display("[TB] FAIL monitor_timeout: %0d entries left, expected 0", expQ.size());
        end
        monitorDone = 1;
    end

    initial begin : driver
        stim_t s;
        reset = 1; clr = 0; mask543 = 0;
        sw1u = 0; sw1d = 0; sw2u = 0; sw2d = 0;
        we0 = 0; we1 = 0; we2 = 0; wd0 = 0; wd1 = 0; wd2 = 0;
        mHold = {3{8'hFF}}; mFlag = 0; mCnt = 0;
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset: everything precharged, no conflict.
        applyStimulus(idle());

        // db0 drives through SW1 and SW2 up to db2, then all segments hold.
        s = idle(); s.we = 3'b001; s.wd0 = 8'h5A; s.s1u = 1; s.s2u = 1;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        // db2 drives down to db0 with and without the [5:3] mask.
        s = idle(); s.we = 3'b100; s.wd2 = 8'hFF; s.s2d = 1; s.s1d = 1; s.mask = 1;
        applyStimulus(s);
        s.mask = 0;
        applyStimulus(s);

        // Both directions on SW1 with both sides driven: conflict.
        s = idle(); s.we = 3'b011; s.wd0 = 8'h11; s.wd1 = 8'h22; s.s1u = 1; s.s1d = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Counter saturation, then clear wins over a simultaneous conflict.
        s = idle(); s.s1u = 1; s.s1d = 1;
        for (int i = 0; i < 20; i++) applyStimulus(s);
        s.clr = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Transfer discarded by reset in the same cycle.
        s = idle(); s.we = 3'b010; s.wd1 = 8'h3C; s.s1d = 1; s.rst = 1;
        applyStimulus(s);
        applyStimulus(idle());

        for (int i = 0; i < 400; i++) begin
            s = stim_t'({$urandom, $urandom});
            s.rst = ($urandom_range(0, 31) == 0);
            s.clr = ($urandom_range(0, 15) == 0);
            applyStimulus(s);
        end
        driverDone = 1;

        wait (monitorDone);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_switch_hold.md
DATA_SWITCH_HOLD -- requirements
Module: data_switch_hold

Interface
REQ-001 The block SHALL have parameter HOLD_RESET_VALUE, default 8'hFF, which is the precharge value loaded into every segment hold register at reset.
REQ-002 The block SHALL have parameter CNT_W, default 4, which is the width of the saturating conflict counter.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high, port reset.
REQ-004 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- bus_sw_1u  in  1  SW1 upstream, db0 -> db1
- bus_sw_1d  in  1  SW1 downstream, db1 -> db0
- bus_sw_2u  in  1  SW2 upstream, db1 -> db2
- bus_sw_2d  in  1  SW2 downstream, db2 -> db1
- bus_sw_mask543_en  in  1  clear bits [5:3] on SW1 downstream path
- db0_we / db0_wd  in  1/8  local driver enable/data, segment 0 (pin side)
- db1_we / db1_wd  in  1/8  local driver enable/data, segment 1 (ALU side)
- db2_we / db2_wd  in  1/8  local driver enable/data, segment 2 (register file side)
- conflict_clr  in  1  clears the sticky conflict flag and the counter
- db0, db1, db2  out  8  resolved segment values, combinational
- bus_conflict  out  1  sticky conflict flag
- conflict_cnt  out  CNT_W  saturating conflict-cycle count

Function
REQ-005 A switch SHALL be active when exactly one of its u/d inputs is high; when both are high, that switch SHALL be treated as open and the cycle SHALL count as a conflict.
REQ-006 Each segment SHALL resolve in priority order: local driver (dbN_we), then the value propagated through an active switch, then hold register N.
REQ-007 Propagation SHALL chain within one cycle: with 1u and 2u active and only db0_we high, db2 SHALL equal db0_wd; likewise db0 SHALL follow db2_wd via 2d and 1d.
REQ-008 The SW1 downstream path SHALL deliver db1 & 8'hC7 to db0 when bus_sw_mask543_en is high; otherwise it SHALL deliver db1 unmasked; mask543_en SHALL have no effect on other paths.
REQ-009 A segment that has a local driver and also receives an active incoming switch SHALL take its local driver value, and the cycle SHALL count as a conflict.
REQ-010 On every non-reset rising edge, hold register N SHALL load resolved dbN, so an undriven segment retains its last value indefinitely.
REQ-011 Outputs db0..db2 SHALL be combinational from the inputs and the hold registers, with zero-cycle latency; the hold update SHALL become visible the cycle after.
REQ-012 On a conflict cycle, bus_conflict SHALL be set at the next edge and SHALL stay set until conflict_clr or reset.
REQ-013 On a conflict cycle, conflict_cnt SHALL increment at the next edge and SHALL saturate at all-ones.
REQ-014 conflict_clr SHALL take priority over a simultaneous conflict: the flag and counter SHALL both go to 0, and that cycle's conflict SHALL NOT be recorded.
REQ-015 The block SHALL contain no other state; all switch inputs SHALL take effect within the same cycle.

Reset
REQ-016 While reset is high at an edge, all hold registers SHALL load HOLD_RESET_VALUE, and bus_conflict and conflict_cnt SHALL load 0.
REQ-017 Reset asserted mid-transfer SHALL discard the transfer; with no drivers in the following cycle, db0..db2 SHALL all read HOLD_RESET_VALUE.
REQ-018 During a reset cycle, the combinational outputs SHALL still reflect the current drivers, while the registers are overwritten.

Verification
REQ-019 Reset, then no drivers and no switches -> db0 = db1 = db2 = 8'hFF; bus_conflict = 0; conflict_cnt = 0.
REQ-020 db0_we = 1, db0_wd = 8'h5A, 1u = 2u = 1 for one cycle, then all inputs low -> db2 = 8'h5A in the drive cycle, and db0..db2 all hold 8'h5A in the following cycles.
REQ-021 db2_wd = 8'hFF, 2d = 1d = 1, mask543_en = 1 -> db1 = 8'hFF and db0 = 8'hC7; the same stimulus with mask543_en = 0 -> db0 = 8'hFF.
REQ-022 1u = 1d = 1 with db0_wd = 8'h11 and db1_wd = 8'h22 (both enabled) -> db0 = 8'h11 and db1 = 8'h22; bus_conflict = 1 next cycle; conflict_cnt = 1.
REQ-023 Twenty consecutive conflict cycles with CNT_W = 4 -> conflict_cnt = 15 (saturated); then conflict_clr together with a conflict -> conflict_cnt = 0 and bus_conflict = 0.
REQ-024 Drive db1 = 8'h3C via 1d for one cycle with reset asserted in that same cycle -> db0 = 8'h3C that cycle, and db0 = 8'hFF the next cycle.
